nfc_way_command_scheduler: RTL and testbench

Multi-way command front-end inserted between the host command port and the command-issue engine of the NAND flash controller. It holds one command FIFO per NAND way (chip enable). A round-robin arbiter forwards one command at a time to the issue engine, and only for ways whose ready/busy line reports ready. This lets commands to idle dies proceed while other dies are busy, which generalises the single-queue path to N ways with configurable queue depth.

---
 rtl/nfc_way_command_scheduler.sv | 257 +++++++++++++++++++++++++
 tb/tb_nfc_way_command_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nfc_way_command_scheduler.sv
// ---------------------------------------------------------------------------
// nfc_way_command_scheduler
//
// Purpose:
//   Multi-way command front-end for the NAND flash controller. Each host
//   command is pushed into a per-way FIFO, where the way is iTargetID.
//   A round-robin arbiter forwards one command at a time to the
//   command-issue engine. It only considers ways that hold a command, whose
//   R/B line reports ready, and whose post-issue guard counter has expired.
//
// Ports:
//   iSystemClock, iReset          clock, asynchronous active-high reset
//   iOpcode/iTargetID/iSourceID/  host command payload
//   iAddress/iLength
//   iCMDValid / oCMDReady         host push handshake
//   oOpcode/oTargetID/oSourceID/  issued command payload (registered)
//   oAddress/oLength
//   oCMDValid / iCMDReady         issue-engine handshake
//   iReadyBusy                    per-way R/B, 1 = ready, already synchronised
//   oQueueFull / oQueueEmpty      per-way FIFO status (registered)
//   oTargetError                  one-cycle pulse after an out-of-range target
//                                 is accepted and dropped
//   oSchedState                   arbiter FSM state, for debug
//   oIssueCount                   per-way 16-bit saturating issue counters;
//                                 present only with NFC_SCHED_ISSUE_STATS_EN
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both 1. While oCMDValid is 1 and iCMDReady is 0, the payload
// outputs hold stable. oCMDReady is combinational from iTargetID and the
// registered full flags. It does not depend on iCMDValid.
//
// Optional feature macro: NFC_SCHED_ISSUE_STATS_EN
// ---------------------------------------------------------------------------
module nfc_way_command_scheduler #(
    parameter int NumberOfWays    = 4,
    parameter int QueueDepth      = 4,
    parameter int BusyGuardCycles = 4
) (
    input  logic                    iSystemClock,
    input  logic                    iReset,
    input  logic [5:0]              iOpcode,
    input  logic [4:0]              iTargetID,
    input  logic [4:0]              iSourceID,
    input  logic [31:0]             iAddress,
    input  logic [15:0]             iLength,
    input  logic                    iCMDValid,
    output logic                    oCMDReady,
    output logic [5:0]              oOpcode,
    output logic [4:0]              oTargetID,
    output logic [4:0]              oSourceID,
    output logic [31:0]             oAddress,
    output logic [15:0]             oLength,
    output logic                    oCMDValid,
    input  logic                    iCMDReady,
    input  logic [NumberOfWays-1:0] iReadyBusy,
    output logic [NumberOfWays-1:0] oQueueFull,
    output logic [NumberOfWays-1:0] oQueueEmpty,
    output logic                    oTargetError,
    output logic [1:0]              oSchedState
`ifdef NFC_SCHED_ISSUE_STATS_EN
   ,output logic [16*NumberOfWays-1:0] oIssueCount
`endif
);

    localparam int WW = $clog2(NumberOfWays);
    localparam int PW = $clog2(QueueDepth);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_ISSUE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [63:0]             mem_q    [NumberOfWays][QueueDepth];
    logic [PW-1:0]           wr_ptr_q [NumberOfWays];
    logic [PW-1:0]           rd_ptr_q [NumberOfWays];
    logic [CW-1:0]           count_q  [NumberOfWays];
    logic [CW-1:0]           count_d  [NumberOfWays];
    logic [3:0]              guard_q  [NumberOfWays];
    logic [NumberOfWays-1:0] full_q, full_d, empty_q, empty_d;
    logic [NumberOfWays-1:0] push_en, pop_en, eligible;

    logic [WW-1:0] last_q, winner_q;
    logic [WW-1:0] rr_idx, idx_hi, idx_lo;
    logic          rr_found, found_hi, found_lo;

    logic          target_ok;
    logic          load_out, issue_hs;
    logic          valid_q, err_q;
    logic [63:0]   in_entry, head_entry, out_q;

    // ---------------- push side ----------------
    assign target_ok = (iTargetID < 5'(NumberOfWays));
    assign in_entry  = {iOpcode, iTargetID, iSourceID, iAddress, iLength};

    // Out-of-range targets are always accepted so the host never stalls on them.
    assign oCMDReady = target_ok ? ~full_q[iTargetID[WW-1:0]] : 1'b1;

    assign issue_hs = (state_q == S_ISSUE) && iCMDReady;

    always_comb begin
        push_en  = '0;
        pop_en   = '0;
        eligible = '0;
        full_d   = '0;
        empty_d  = '0;
        for (int w = 0; w < NumberOfWays; w++) begin
            // Full is taken from the registered flag: a full queue refuses a
            // push even in the cycle that it pops.
            push_en[w]  = iCMDValid && target_ok && (iTargetID == 5'(w)) && !full_q[w];
            pop_en[w]   = issue_hs && (winner_q == WW'(w));
            count_d[w]  = count_q[w] + CW'(push_en[w]) - CW'(pop_en[w]);
            full_d[w]   = (count_d[w] == CW'(QueueDepth));
            empty_d[w]  = (count_d[w] == '0);
            eligible[w] = !empty_q[w] && iReadyBusy[w] && (guard_q[w] == 4'd0);
        end
    end

    // ---------------- round-robin search ----------------
    // The first eligible way above lastGrant wins. If there is none, the
    // first eligible way at or below lastGrant wins. This is the same as a
    // modulo search that starts at lastGrant+1.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int w = 0; w < NumberOfWays; w++) begin
            if (eligible[w] && (WW'(w) > last_q) && !found_hi) begin
                found_hi = 1'b1;
                idx_hi   = WW'(w);
            end
            if (eligible[w] && (WW'(w) <= last_q) && !found_lo) begin
                found_lo = 1'b1;
                idx_lo   = WW'(w);
            end
        end
        rr_found = found_hi || found_lo;
        rr_idx   = found_hi ? idx_hi : idx_lo;
    end

    assign head_entry = mem_q[rr_idx][rd_ptr_q[rr_idx]];

    // ---------------- arbiter FSM ----------------
    always_comb begin
        state_d  = state_q;
        load_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|eligible) state_d = S_SELECT;
            end
            S_SELECT: begin
                // Eligibility is re-evaluated here. R/B may have dropped
                // since IDLE.
                if (rr_found) begin
                    load_out = 1'b1;
                    state_d  = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                // Once a command is presented it is never withdrawn.
                if (iCMDReady) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            out_q    <= '0;
            winner_q <= '0;
            last_q   <= WW'(NumberOfWays - 1);
        end else begin
            state_q <= state_d;
            err_q   <= iCMDValid && !target_ok;
            if (load_out) begin
                valid_q  <= 1'b1;
                out_q    <= head_entry;
                winner_q <= rr_idx;
            end else if (issue_hs) begin
                valid_q <= 1'b0;
                last_q  <= winner_q;
            end
        end
    end

    // ---------------- per-way queue state ----------------
    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            full_q  <= '0;
            empty_q <= '1;
            for (int w = 0; w < NumberOfWays; w++) begin
                wr_ptr_q[w] <= '0;
                rd_ptr_q[w] <= '0;
                count_q[w]  <= '0;
                guard_q[w]  <= '0;
            end
        end else begin
            full_q  <= full_d;
            empty_q <= empty_d;
            for (int w = 0; w < NumberOfWays; w++) begin
                count_q[w] <= count_d[w];
                if (push_en[w]) wr_ptr_q[w] <= wr_ptr_q[w] + 1'b1;
                if (pop_en[w])  rd_ptr_q[w] <= rd_ptr_q[w] + 1'b1;
                // A fresh issue reloads the guard. This covers the time the
                // die takes to pull R/B low.
                if (pop_en[w])
                    guard_q[w] <= 4'(BusyGuardCycles);
                else if (guard_q[w] != 4'd0)
                    guard_q[w] <= guard_q[w] - 4'd1;
            end
        end
    end

    // Queue storage has no reset. The pointers and counts define validity.
    always_ff @(posedge iSystemClock) begin
        for (int w = 0; w < NumberOfWays; w++) begin
            if (push_en[w]) mem_q[w][wr_ptr_q[w]] <= in_entry;
        end
    end

`ifdef NFC_SCHED_ISSUE_STATS_EN
    logic [15:0] stat_q [NumberOfWays];

    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            for (int w = 0; w < NumberOfWays; w++) stat_q[w] <= '0;
        end else begin
            for (int w = 0; w < NumberOfWays; w++) begin
                if (pop_en[w] && (stat_q[w] != 16'hFFFF)) stat_q[w] <= stat_q[w] + 16'd1;
            end
        end
    end

    always_comb begin
        oIssueCount = '0;
        for (int w = 0; w < NumberOfWays; w++) oIssueCount[16*w +: 16] = stat_q[w];
    end
`endif

    // ---------------- outputs ----------------
    assign {oOpcode, oTargetID, oSourceID, oAddress, oLength} = out_q;
    assign oCMDValid    = valid_q;
    assign oTargetError = err_q;
    assign oQueueFull   = full_q;
    assign oQueueEmpty  = empty_q;
    assign oSchedState  = state_q;

endmodule

// File: tb/tb_nfc_way_command_scheduler.sv
// ---------------------------------------------------------------------------
// tb_nfc_way_command_scheduler
//
// Directed bench for nfc_way_command_scheduler with the default parameters
// (4 ways, depth 4, guard 4). A posedge monitor logs every issue handshake:
// target, opcode and cycle. The directed sequences compare that log and the
// status outputs against hand-derived expectations.
// ---------------------------------------------------------------------------
module tb_nfc_way_command_scheduler;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode_i;
    logic [4:0]  target_i, source_i;
    logic [31:0] address_i;
    logic [15:0] length_i;
    logic        cmd_valid_i, cmd_ready_o;
    logic [5:0]  opcode_o;
    logic [4:0]  target_o, source_o;
    logic [31:0] address_o;
    logic [15:0] length_o;
    logic        cmd_valid_o, cmd_ready_i;
    logic [N-1:0] ready_busy;
    logic [N-1:0] queue_full, queue_empty;
    logic        target_error;
    logic [1:0]  sched_state;
`ifdef NFC_SCHED_ISSUE_STATS_EN
    logic [16*N-1:0] issue_count;
`endif

    always #5 clk = ~clk;

    nfc_way_command_scheduler #(
        .NumberOfWays(N), .QueueDepth(4), .BusyGuardCycles(4)
    ) dut (
        .iSystemClock(clk),
        .iReset      (rst),
        .iOpcode     (opcode_i),
        .iTargetID   (target_i),
        .iSourceID   (source_i),
        .iAddress    (address_i),
        .iLength     (length_i),
        .iCMDValid   (cmd_valid_i),
        .oCMDReady   (cmd_ready_o),
        .oOpcode     (opcode_o),
        .oTargetID   (target_o),
        .oSourceID   (source_o),
        .oAddress    (address_o),
        .oLength     (length_o),
        .oCMDValid   (cmd_valid_o),
        .iCMDReady   (cmd_ready_i),
        .iReadyBusy  (ready_busy),
        .oQueueFull  (queue_full),
        .oQueueEmpty (queue_empty),
        .oTargetError(target_error),
        .oSchedState (sched_state)
`ifdef NFC_SCHED_ISSUE_STATS_EN
       ,.oIssueCount (issue_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- issue monitor ----------------
    int         cyc = 0;
    logic [4:0] iss_tgt[$];
    logic [5:0] iss_opc[$];
    int         iss_cyc[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && cmd_valid_o && cmd_ready_i) begin
            iss_tgt.push_back(target_o);
            iss_opc.push_back(opcode_o);
            iss_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        iss_tgt.delete();
        iss_opc.delete();
        iss_cyc.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_cmd(input logic [4:0] tgt, input logic [5:0] opc);
        cmd_valid_i = 1'b1;
        target_i    = tgt;
        opcode_i    = opc;
        source_i    = 5'(opc);
        address_i   = {26'h0, opc};
        length_i    = {10'h0, opc};
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_issues(input int n, input int budget);
        int k;
        k = 0;
        while (iss_tgt.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    function automatic logic [5:0] log_opc(input int i);
        return (i < iss_opc.size()) ? iss_opc[i] : 6'h3F;
    endfunction

    function automatic logic [4:0] log_tgt(input int i);
        return (i < iss_tgt.size()) ? iss_tgt[i] : 5'h1F;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [4:0] exp_tgt [6];
        logic [5:0] exp_opc [6];
        exp_tgt = '{5'd0, 5'd1, 5'd2, 5'd0, 5'd1, 5'd2};
        exp_opc = '{6'h10, 6'h20, 6'h30, 6'h11, 6'h21, 6'h31};

        rst = 1'b1;
        cmd_valid_i = 1'b0; cmd_ready_i = 1'b0;
        opcode_i = '0; target_i = '0; source_i = '0; address_i = '0; length_i = '0;
        ready_busy = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_eq("rst_valid", cmd_valid_o, 0);
        check_eq("rst_empty", queue_empty, 4'hF);
        check_eq("rst_full", queue_full, 0);
        check_eq("rst_err", target_error, 0);
        check_eq("rst_opcode", opcode_o, 0);
        check_eq("rst_state", sched_state, 0);

        // Test 1: single command latency, push at edge E0, valid after E2
        cmd_ready_i = 1'b1;
        cmd_valid_i = 1'b1; target_i = 5'd0; opcode_i = 6'h01;
        #1 check_eq("t1_cmd_ready", cmd_ready_o, 1);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check_eq("t1_e0_empty", queue_empty, 4'hE);
        check_eq("t1_e0_valid", cmd_valid_o, 0);
        @(negedge clk);
        check_eq("t1_e1_valid", cmd_valid_o, 0);
        @(negedge clk);
        check_eq("t1_e2_valid", cmd_valid_o, 1);
        check_eq("t1_e2_target", target_o, 0);
        check_eq("t1_e2_opcode", opcode_o, 6'h01);
        @(negedge clk);
        check_eq("t1_e3_valid", cmd_valid_o, 0);
        check_eq("t1_e3_empty", queue_empty, 4'hF);
        check_eq("t1_issues", iss_tgt.size(), 1);

        // Test 2: round-robin over ways 0..2, two commands each
        repeat (10) @(negedge clk);
        clear_log();
        push_cmd(5'd0, 6'h10); push_cmd(5'd0, 6'h11);
        push_cmd(5'd1, 6'h20); push_cmd(5'd1, 6'h21);
        push_cmd(5'd2, 6'h30); push_cmd(5'd2, 6'h31);
        wait_issues(6, 100);
        check_eq("t2_issue_count", iss_tgt.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("t2_target_%0d", i), log_tgt(i), exp_tgt[i]);
            check_eq($sformatf("t2_opcode_%0d", i), log_opc(i), exp_opc[i]);
        end
        if (iss_cyc.size() >= 4)
            check_eq("t2_way0_guard_gap", (iss_cyc[3] - iss_cyc[0]) >= 4, 1);
        else
            check_eq("t2_way0_guard_gap_missing", iss_cyc.size(), 4);

        // Test 3: way 1 busy, so only way 2 issues until R/B rises
        repeat (10) @(negedge clk);
        clear_log();
        ready_busy = 4'b1101;
        push_cmd(5'd1, 6'h40);
        push_cmd(5'd2, 6'h41);
        repeat (15) @(negedge clk);
        check_eq("t3_busy_issue_count", iss_tgt.size(), 1);
        check_eq("t3_busy_target", log_tgt(0), 2);
        check_eq("t3_way1_pending", queue_empty[1], 0);
        ready_busy = 4'hF;
        wait_issues(2, 30);
        check_eq("t3_ready_issue_count", iss_tgt.size(), 2);
        check_eq("t3_ready_target", log_tgt(1), 1);
        check_eq("t3_ready_opcode", log_opc(1), 6'h40);

        // Test 4: fill way 3 while the issue engine stalls
        repeat (10) @(negedge clk);
        clear_log();
        cmd_ready_i = 1'b0;
        push_cmd(5'd3, 6'h2A); push_cmd(5'd3, 6'h2B);
        push_cmd(5'd3, 6'h2C); push_cmd(5'd3, 6'h2D);
        repeat (3) @(negedge clk);
        check_eq("t4_full3", queue_full[3], 1);
        check_eq("t4_hold_valid", cmd_valid_o, 1);
        check_eq("t4_hold_target", target_o, 3);
        check_eq("t4_hold_opcode", opcode_o, 6'h2A);
        cmd_valid_i = 1'b1; target_i = 5'd3; opcode_i = 6'h2E;
        #1 check_eq("t4_ready_t3", cmd_ready_o, 0);
        target_i = 5'd0; opcode_i = 6'h05;
        #1 check_eq("t4_ready_t0", cmd_ready_o, 1);
        @(negedge clk);
        // Pop cycle: the push to the full way 3 must be refused.
        target_i = 5'd3; opcode_i = 6'h2E; cmd_ready_i = 1'b1;
        #1 check_eq("t4_ready_t3_pop", cmd_ready_o, 0);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check_eq("t4_full3_after_pop", queue_full[3], 0);
        check_eq("t4_way0_pending", queue_empty[0], 0);
        check_eq("t4_pop_count", iss_tgt.size(), 1);
        check_eq("t4_pop_opcode", log_opc(0), 6'h2A);
        wait_issues(5, 60);
        repeat (20) @(negedge clk);
        check_eq("t4_drain_count", iss_tgt.size(), 5);
        check_eq("t4_drain_way0", log_opc(1), 6'h05);
        check_eq("t4_drain_last", log_opc(4), 6'h2D);
        check_eq("t4_drain_empty", queue_empty, 4'hF);

        // Test 5: out-of-range target dropped with a one-cycle error pulse
        clear_log();
        cmd_valid_i = 1'b1; target_i = 5'd7; opcode_i = 6'h3F;
        #1 check_eq("t5_ready", cmd_ready_o, 1);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check_eq("t5_err_pulse", target_error, 1);
        check_eq("t5_empty", queue_empty, 4'hF);
        @(negedge clk);
        check_eq("t5_err_clear", target_error, 0);
        repeat (10) @(negedge clk);
        check_eq("t5_no_issue", iss_tgt.size(), 0);

        // Test 6: asynchronous reset while in ISSUE
        cmd_ready_i = 1'b0;
        push_cmd(5'd0, 6'h15);
        repeat (3) @(negedge clk);
        check_eq("t6_pre_valid", cmd_valid_o, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_rst_valid", cmd_valid_o, 0);
        check_eq("t6_rst_empty", queue_empty, 4'hF);
        check_eq("t6_rst_opcode", opcode_o, 0);
        check_eq("t6_rst_state", sched_state, 0);
`ifdef NFC_SCHED_ISSUE_STATS_EN
        check_eq("t6_rst_stats", issue_count, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmd_ready_i = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("t6_cmd_lost", cmd_valid_o, 0);
        check_eq("t6_post_empty", queue_empty, 4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
